// File: rtl/mdu_seq.sv
// mdu_seq: iterative RV32M multiply/divide sequencer (radix-2 shift-add multiply, restoring divide).
// Define MDU_EARLY_OUT_EN to shortcut zero-operand multiplies and |a|<|b| divides to one cycle.
module mdu_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] DIV  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [1:0]        fn_q, fn_d;
  logic [XLEN-1:0]   mcand_q, mcand_d;
  logic [XLEN-1:0]   dvsr_q, dvsr_d;
  logic [XLEN-1:0]   quo_q, quo_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [2*XLEN-1:0] prod_q, prod_d;
  logic              neg_res_q, neg_res_d;
  logic              neg_rem_q, neg_rem_d;

  logic            a_sgn, b_sgn, a_neg, b_neg;
  logic            div_ovf, early_mul, early_div;
  logic [XLEN-1:0] a_mag, b_mag;

  assign a_sgn   = (funct3 == 3'b001) | (funct3 == 3'b010) | (funct3[2] & ~funct3[0]);
  assign b_sgn   = (funct3 == 3'b001) | (funct3[2] & ~funct3[0]);
  assign a_neg   = a_sgn & op_a[XLEN-1];
  assign b_neg   = b_sgn & op_b[XLEN-1];
  assign a_mag   = a_neg ? -op_a : op_a;
  assign b_mag   = b_neg ? -op_b : op_b;
  assign div_ovf = funct3[2] & ~funct3[0] & (op_a == {1'b1, {(XLEN-1){1'b0}}}) & (&op_b);

`ifdef MDU_EARLY_OUT_EN
  assign early_mul = (op_a == '0) | (op_b == '0);
  assign early_div = a_mag < b_mag;
`else
  assign early_mul = 1'b0;
  assign early_div = 1'b0;
`endif

  // One iteration of each algorithm plus the sign-corrected view of that step's outcome.
  logic [XLEN:0]     psum, rshift, rdiff;
  logic [2*XLEN-1:0] prod_step, prod_fix;
  logic [XLEN-1:0]   quo_step, rem_step, quo_fix, rem_fix;

  always_comb begin
    psum      = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    prod_step = {psum, prod_q[XLEN-1:1]};
    prod_fix  = neg_res_q ? -prod_step : prod_step;
    rshift    = {rem_q, quo_q[XLEN-1]};
    rdiff     = rshift - {1'b0, dvsr_q};
    if (!rdiff[XLEN]) begin
      rem_step = rdiff[XLEN-1:0];
      quo_step = {quo_q[XLEN-2:0], 1'b1};
    end else begin
      rem_step = rshift[XLEN-1:0];
      quo_step = {quo_q[XLEN-2:0], 1'b0};
    end
    quo_fix = neg_res_q ? -quo_step : quo_step;
    rem_fix = neg_rem_q ? -rem_step : rem_step;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    fn_d      = fn_q;
    mcand_d   = mcand_q;
    dvsr_d    = dvsr_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    prod_d    = prod_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          fn_d      = funct3[1:0];
          mcand_d   = a_mag;
          dvsr_d    = b_mag;
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          cnt_d     = '0;
          prod_d    = {{XLEN{1'b0}}, b_mag};
          rem_d     = '0;
          quo_d     = a_mag;
          if (!funct3[2]) begin
            if (early_mul) begin
              state_d  = DONE;
              result_d = '0;
            end else begin
              state_d = MUL;
            end
          end else if (op_b == '0) begin
            state_d  = DONE;
            result_d = funct3[1] ? op_a : '1;
          end else if (div_ovf) begin
            state_d  = DONE;
            result_d = funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
          end else if (early_div) begin
            state_d  = DONE;
            result_d = funct3[1] ? op_a : '0;
          end else begin
            state_d = DIV;
          end
        end
      end
      MUL: begin
        prod_d = prod_step;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(XLEN-1)) begin
          state_d  = DONE;
          cnt_d    = '0;
          result_d = (fn_q == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        end
      end
      DIV: begin
        quo_d = quo_step;
        rem_d = rem_step;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(XLEN-1)) begin
          state_d  = DONE;
          cnt_d    = '0;
          result_d = fn_q[1] ? rem_fix : quo_fix;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Flush overrides everything, including an accept or a completing step.
    if (flush) begin
      state_d  = IDLE;
      cnt_d    = '0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      fn_q      <= '0;
      mcand_q   <= '0;
      dvsr_q    <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      prod_q    <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      fn_q      <= fn_d;
      mcand_q   <= mcand_d;
      dvsr_q    <= dvsr_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      prod_q    <= prod_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
    end
  end

  assign busy   = state_q != IDLE;
  assign done   = (state_q == DONE) & ~flush;
  assign stall  = (start & (state_q == IDLE)) | (busy & ~done);
  assign result = result_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Scoreboard bench for mdu_seq: random RV32M ops checked against 64-bit arithmetic reference.
module tb_mdu_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        busy, stall, done;
  logic [31:0] result;

  mdu_seq #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .funct3(funct3),
    .op_a  (op_a),
    .op_b  (op_b),
    .flush (flush),
    .busy  (busy),
    .stall (stall),
    .done  (done),
    .result(result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    int          due;
  } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          bad = 0;
  logic        in_flight = 1'b0;
  int          due = 0;
  logic [31:0] last_res = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    p  = '0;
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = sa / sb;
        return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        p = sa % sb;
        return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  // Cycles from the cycle start is presented to the cycle done is high (that cycle = 0).
  function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
`ifdef MDU_EARLY_OUT_EN
    logic        as, bs;
    logic [31:0] ma, mb;
`endif
    if (f[2] && b == 0) return 1;
    if (f[2] && !f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MDU_EARLY_OUT_EN
    as = (f == 3'd1) || (f == 3'd2) || (f[2] && !f[0]);
    bs = (f == 3'd1) || (f[2] && !f[0]);
    ma = (as && a[31]) ? -a : a;
    mb = (bs && b[31]) ? -b : b;
    if (!f[2] && (a == 0 || b == 0)) return 1;
    if (f[2] && ma < mb) return 1;
`endif
    return 33;
  endfunction

  // Monitor: pops the scoreboard whenever done is seen; also checks stall every cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("stall", {31'b0, stall}, {31'b0, in_flight ? (cyc != due) : start});
      if (done) begin
        if (q.size() == 0) begin
          chk("spurious_done", {31'b0, done}, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("result", result, e.res);
          chk("latency_cycle", cyc, e.due);
        end
        in_flight = 1'b0;
      end
    end
  end

  // Called just after a rising edge; returns just after the edge following the done cycle.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input bit noise);
    exp_t e;
    flush     = 1'b0;
    start     = 1'b1;
    funct3    = f;
    op_a      = a;
    op_b      = b;
    e.res     = ref_res(f, a, b);
    e.due     = cyc + exp_lat(f, a, b);
    due       = e.due;
    last_res  = e.res;
    q.push_back(e);
    in_flight = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (cyc > due) break;
      if (noise) begin
        start  = 1'($urandom_range(0, 1));
        funct3 = 3'($urandom);
        op_a   = $urandom;
        op_b   = $urandom;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    chk("done_missing", {31'b0, in_flight}, 32'd0);
    in_flight = 1'b0;
    q.delete();
  endtask

  task automatic flush_mid_op;
    start     = 1'b1;
    funct3    = 3'b000;
    op_a      = 32'd123;
    op_b      = 32'd456;
    due       = cyc + 1000;
    in_flight = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush     = 1'b0;
    in_flight = 1'b0;
    @(negedge clk);
    chk("flush_busy", {31'b0, busy}, 32'd0);
    chk("flush_result_kept", result, last_res);
    @(posedge clk);
    #1;
  endtask

  task automatic flush_with_start;
    start  = 1'b1;
    flush  = 1'b1;
    funct3 = 3'b101;
    op_a   = 32'd9;
    op_b   = 32'd0;
    @(posedge clk);
    #1;
    start = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_start_busy", {31'b0, busy}, 32'd0);
    chk("flush_start_result", result, last_res);
    @(posedge clk);
    #1;
  endtask

  task automatic reset_mid_div;
    start     = 1'b1;
    funct3    = 3'b101;
    op_a      = 32'd1000;
    op_b      = 32'd7;
    due       = cyc + 1000;
    in_flight = 1'b1;
    repeat (15) begin
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    #1 rst_n = 1'b0;
    #1;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    in_flight = 1'b0;
    last_res  = '0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_done", {31'b0, done}, 32'd0);
    chk("reset_stall", {31'b0, stall}, 32'd0);
    chk("reset_result", result, 32'd0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_op(3'b000, 32'd7, 32'hFFFF_FFFD, 1'b0);
    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(3'b100, -32'sd7, 32'd2, 1'b0);
    run_op(3'b110, -32'sd7, 32'd2, 1'b0);
    run_op(3'b101, 32'd100, 32'd7, 1'b1);
    run_op(3'b111, 32'd100, 32'd7, 1'b1);
    run_op(3'b101, 32'd5, 32'd0, 1'b0);
    run_op(3'b110, 32'd5, 32'd0, 1'b0);
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(3'b010, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b0);
    run_op(3'b000, 32'd0, 32'd5, 1'b0);
    run_op(3'b100, 32'd3, -32'sd9, 1'b0);

    flush_mid_op();
    run_op(3'b000, 32'd12, 32'd11, 1'b0);
    flush_with_start();
    reset_mid_div();
    run_op(3'b101, 32'd100, 32'd7, 1'b0);

    for (int i = 0; i < 200; i++) begin
      logic [2:0]  f;
      logic [31:0] a, b;
      f = 3'($urandom);
      a = pick();
      b = pick();
      run_op(f, a, b, 1'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
- Iterative RV32M multiply/divide sequencer sitting beside the main ALU in the EX stage.
- Accepts one M-extension operation per request and runs a radix-2 shift-add multiply or restoring divide over XLEN cycles.
- Raises a stall to the pipeline while the operation runs and returns a registered result with a one-cycle done pulse.
- Decode supplies funct3 directly.

Parameters:
- XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in IDLE
- funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- op_a  in  XLEN  rs1 value (multiplicand/dividend)
- op_b  in  XLEN  rs2 value (multiplier/divisor)
- flush  in  1  abort in-flight operation
- busy  out  1  high in MUL/DIV/DONE states
- stall  out  1  combinational: (start & state==IDLE) | (busy & ~done)
- done  out  1  one-cycle pulse, result valid
- result  out  XLEN  registered result, held until next accepted start

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (rst_n=0, asynchronous): state=IDLE, busy=0, done=0, result=0, counter=0, all internal registers 0.
- States: IDLE, MUL, DIV, DONE.
- IDLE, start=1:
  - Latch funct3 and operand magnitudes plus result-sign flags.
  - Signedness: a signed for MULH, MULHSU, DIV, REM; b signed for MULH, DIV, REM.
  - Transitions:
    - funct3[2]=0 -> MUL.
    - funct3[2]=1 with op_b==0 -> DONE directly (divide-by-zero: quotient all-ones, remainder = op_a).
    - DIV/REM with op_a=0x80000000 and op_b=0xFFFFFFFF -> DONE directly (overflow: quotient 0x80000000, remainder 0).
    - Otherwise -> DIV.
- MUL: one shift-add step per cycle into a 2*XLEN product register; counter 0..XLEN-1; at counter==XLEN-1 -> DONE.
- DIV: one restoring step per cycle (shift remainder, trial subtract, set quotient bit); at counter==XLEN-1 -> DONE.
- DONE:
  - Apply sign correction: product negated if signs differ; quotient negated if signs differ; remainder takes the dividend sign.
  - Select result:
    - MUL -> low half.
    - MULH/MULHSU/MULHU -> high half.
    - DIV/DIVU -> quotient.
    - REM/REMU -> remainder.
  - done=1 for exactly this cycle, then IDLE.
- Latency: start at edge N; normal op has done high in cycle N+XLEN+1 (33 for XLEN=32). Special-case divide has done in cycle N+1.
- start while busy: ignored; operands not re-latched.
- start in the same cycle as done: ignored; accepted once back in IDLE.
- flush: synchronous, highest priority in every state. Next state IDLE, done forced 0 that cycle, result unchanged, counter cleared. flush together with start in IDLE means no accept.
- Mid-operation rst_n assertion: immediate return to reset values; no done.
- Widths: all arithmetic at XLEN+1 bits internally; the product never truncates before the final select.

Optional Feature:
- MDU_EARLY_OUT_EN.
- Defined: on accept, MUL-class ops with op_a==0 or op_b==0 go directly to DONE with result 0. Unsigned-magnitude divides with |a|<|b| go directly to DONE with quotient 0 and remainder op_a. Latency for these is 1.
- Undefined: these cases run the full XLEN iterations with identical final results.
- Divide-by-zero and overflow shortcuts are present in both builds.

Test Plan:
- MUL 7 x -3 (op_a=7, op_b=0xFFFFFFFD, funct3=000) -> done at cycle 33, result=0xFFFFFFEB; stall high cycles 0..32.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> result=0xFFFFFFFE; MULH same operands -> result=0x00000000.
- DIV -7/2 -> result=0xFFFFFFFD; REM -7/2 -> result=0xFFFFFFFF; DIVU 100/7 -> 14, REMU 100/7 -> 2.
- DIVU 5/0 -> done in cycle 1, result=0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 in cycle 1.
- Start MUL, assert flush at cycle 10 -> IDLE next cycle, no done pulse, result keeps prior value; new start at cycle 12 accepted.
- rst_n low at cycle 15 of DIV -> busy, done, result = 0 immediately. MDU_EARLY_OUT_EN build: MUL 0 x 5 -> done in cycle 1, result 0.
